regfile_dump: RTL and testbench
===============================

Name: regfile_dump

Overview:
- Read-side engine for the 32x32 register file.
- On a Start pulse it walks a programmable register range through one regfile read port.
- Each word is presented as an indexed valid/ready stream for debug/trace logic.
- A 32-bit additive checksum of the dumped words is reported on completion.
- Sits beside the datapath and shares the regfile read-port address (A/B port select is done outside this block).

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width (32 registers).

Ports:
- Clk  input  1  clock, all state changes on rising edge.
- Clr  input  1  synchronous active-high reset.
- Start  input  1  begin dump; sampled only in IDLE.
- Abort  input  1  terminate dump in progress.
- First  input  ADDR_W  first index, captured on accepted Start.
- Last  input  ADDR_W  last index, captured on accepted Start.
- Ra  output  ADDR_W  read address to regfile port.
- Qa  input  DATA_W  combinational read data from regfile for Ra (reg 0 reads 0).
- Valid  output  1  Dout/Idx hold a word.
- Ready  input  1  sink accepts word when Valid&Ready.
- Dout  output  DATA_W  dumped word.
- Idx  output  ADDR_W  register index of Dout.
- Busy  output  1  high in FETCH/SEND.
- Done  output  1  one-cycle pulse after last word accepted.
- Sum  output  DATA_W  running checksum, final value valid when Done.

Behaviour:
- Reset: Clk, synchronous active-high Clr; Clr wins over every other input, including mid-dump.
- Reset values: state IDLE, Ra=0, Valid=0, Dout=0, Idx=0, Busy=0, Done=0, Sum=0; captured First/Last=0.
- States:
  - IDLE.
  - FETCH: Ra=cur; Dout<=Qa, Idx<=cur at end of cycle.
  - SEND: Valid=1, Dout/Idx stable until handshake.
  - DONE: Done=1 for exactly one cycle, then IDLE.
- IDLE -> FETCH on Start:
  - cur<=First, end<=Last, Sum<=0.
  - Start is ignored while Busy or in DONE.
- FETCH -> SEND always after 1 cycle.
- SEND with Ready=1:
  - Sum<=Sum+Dout (mod 2^DATA_W).
  - If cur==end -> DONE, else cur<=cur+1 -> FETCH.
- SEND with Ready=0: hold; Valid never drops without handshake (except Abort/Clr).
- Index increment wraps modulo 2^ADDR_W (31->0):
  - First>Last dumps First..31,0..Last.
  - First==Last dumps one word.
- Latency: Start at cycle t -> Ra=First in t+1 -> Valid=1 in t+2. Max throughput 1 word / 2 cycles.
- Ra is held at the last driven value outside FETCH.
- Snapshot rule: Dout is the regfile value at the FETCH cycle. Regfile writes to that index after FETCH do not alter the pending word.
- Abort (any of FETCH/SEND): next state IDLE, Valid=0, no Done.
  - Sum keeps its partial value.
  - Abort together with Valid&Ready: Abort wins, the beat is not counted in Sum.
- Abort in IDLE/DONE: no effect; the DONE pulse still completes.
- Start and Abort together in IDLE: Start accepted.
- Busy = (state==FETCH || state==SEND).

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE=2'd0, FETCH=2'd1, SEND=2'd2, DONE=2'd3);
  - REG_COUNT=32;
  - the DATA_W/ADDR_W defaults shared with the regfile.
- Single module; no sub-module needed. The checksum accumulator stays inline.

Test Plan:
- Preload regfile R1=1, R2=2, R3=3. Start First=1, Last=3, Ready=1 -> three beats with Idx 1,2,3 and Dout 1,2,3; Valid in cycles t+2, t+4, t+6; Done pulse one cycle after the last beat; Sum=6.
- First=0, Last=0 -> one beat Idx=0, Dout=0, Sum=0, Done pulsed once.
- R31=0xFFFFFFFF, R0=0, R1=5; Start First=31, Last=1 -> Idx order 31,0,1; Sum=0x00000004 (wrap add).
- Backpressure: Ready=0 for 5 cycles on the first beat -> Valid, Dout and Idx stable throughout; Sum unchanged until Ready=1; a Start pulse during the dump is ignored.
- Abort with Valid=1 and Ready=1 on the second beat of 1..3 -> Sum=1, Valid=0 next cycle, no Done, IDLE. A new Start works normally afterwards.
- Clr asserted mid-dump in SEND -> next cycle all outputs at reset values, state IDLE.
- Regfile write to R2 (0xAA) during the SEND of R2 (old 2) -> Dout stays 2.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// rtl/regfile_dump_pkg.sv - shared constants and state encoding for the regfile dump engine
//   Holds the DATA_W/ADDR_W defaults shared with the regfile, the register
//   count and the dump FSM state encoding.
package regfile_dump_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_COUNT  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - read-side engine that streams a register range out of the regfile
//   Clk/Clr         : clock, synchronous active-high reset
//   Start/Abort     : begin a dump (IDLE only) / terminate a dump in progress
//   First/Last      : inclusive index range, captured on an accepted Start
//   Ra/Qa           : regfile read address and its combinational read data
//   Valid/Ready     : word handshake carrying Dout and its register index Idx
//   Busy/Done/Sum   : FETCH or SEND active / one-cycle completion pulse / additive checksum
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              Start,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] First,
  input  logic [ADDR_W-1:0] Last,
  output logic [ADDR_W-1:0] Ra,
  input  logic [DATA_W-1:0] Qa,
  output logic              Valid,
  input  logic              Ready,
  output logic [DATA_W-1:0] Dout,
  output logic [ADDR_W-1:0] Idx,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Sum
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] ra_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] sum_q;

  // A beat only counts when the sink takes it and no abort overrides it.
  logic beat_accept;
  assign beat_accept = (state_q == ST_SEND) && Ready && !Abort;

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (Start) state_d = ST_FETCH;
      ST_FETCH: state_d = Abort ? ST_IDLE : ST_SEND;
      ST_SEND: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else if (Ready) begin
          state_d = (cur_q == last_q) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Valid = 1'b0;
    Busy  = 1'b0;
    Done  = 1'b0;
    case (state_q)
      ST_FETCH: Busy = 1'b1;
      ST_SEND: begin
        Busy  = 1'b1;
        Valid = 1'b1;
      end
      ST_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

  // Ra is registered and loaded with the index about to be fetched, so it
  // equals cur during FETCH and simply holds its last value elsewhere.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      cur_q  <= '0;
      last_q <= '0;
      ra_q   <= '0;
      idx_q  <= '0;
      dout_q <= '0;
      sum_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            cur_q  <= First;
            last_q <= Last;
            ra_q   <= First;
            sum_q  <= '0;
          end
        end
        ST_FETCH: begin
          // Snapshot: later regfile writes cannot disturb the pending word.
          if (!Abort) begin
            dout_q <= Qa;
            idx_q  <= cur_q;
          end
        end
        ST_SEND: begin
          if (beat_accept) begin
            sum_q <= sum_q + dout_q;
            if (cur_q != last_q) begin
              // Index wraps modulo 2^ADDR_W so First>Last runs through 0.
              cur_q <= cur_q + 1'b1;
              ra_q  <= cur_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign Ra   = ra_q;
  assign Dout = dout_q;
  assign Idx  = idx_q;
  assign Sum  = sum_q;

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - directed self-checking bench for regfile_dump
module tb_regfile_dump;

  logic        Clk = 1'b0;
  logic        Clr;
  logic        Start;
  logic        Abort;
  logic [4:0]  First;
  logic [4:0]  Last;
  logic [4:0]  Ra;
  logic [31:0] Qa;
  logic        Valid;
  logic        Ready;
  logic [31:0] Dout;
  logic [4:0]  Idx;
  logic        Busy;
  logic        Done;
  logic [31:0] Sum;

  logic [31:0] regs [32];

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  assign Qa = (Ra == 5'd0) ? 32'd0 : regs[Ra];

  regfile_dump #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clk(Clk), .Clr(Clr), .Start(Start), .Abort(Abort),
    .First(First), .Last(Last), .Ra(Ra), .Qa(Qa),
    .Valid(Valid), .Ready(Ready), .Dout(Dout), .Idx(Idx),
    .Busy(Busy), .Done(Done), .Sum(Sum)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
    First = f;
    Last  = l;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Expects to be in FETCH of idx; leaves the bench one cycle after the
  // SEND beat was accepted (Ready must be 1).
  task automatic expect_beat(input string tag, input logic [4:0] idx, input logic [31:0] dat);
    chk({tag, "_fetch_busy"}, {31'd0, Busy}, 32'd1);
    chk({tag, "_fetch_valid"}, {31'd0, Valid}, 32'd0);
    chk({tag, "_fetch_ra"}, {27'd0, Ra}, {27'd0, idx});
    tick();
    chk({tag, "_send_valid"}, {31'd0, Valid}, 32'd1);
    chk({tag, "_send_idx"}, {27'd0, Idx}, {27'd0, idx});
    chk({tag, "_send_dout"}, Dout, dat);
    tick();
  endtask

  task automatic expect_done(input string tag, input logic [31:0] sum_exp);
    chk({tag, "_done"}, {31'd0, Done}, 32'd1);
    chk({tag, "_done_busy"}, {31'd0, Busy}, 32'd0);
    chk({tag, "_sum"}, Sum, sum_exp);
    tick();
    chk({tag, "_done_once"}, {31'd0, Done}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    Clr = 1'b1; Start = 1'b0; Abort = 1'b0; Ready = 1'b1;
    First = 5'd0; Last = 5'd0;
    tick();
    tick();
    Clr = 1'b0;

    chk("rst_valid", {31'd0, Valid}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_ra", {27'd0, Ra}, 32'd0);
    chk("rst_dout", Dout, 32'd0);
    chk("rst_idx", {27'd0, Idx}, 32'd0);
    chk("rst_sum", Sum, 32'd0);

    // Basic range 1..3
    regs[1] = 32'd1; regs[2] = 32'd2; regs[3] = 32'd3;
    start_dump(5'd1, 5'd3);
    expect_beat("t1b1", 5'd1, 32'd1);
    expect_beat("t1b2", 5'd2, 32'd2);
    expect_beat("t1b3", 5'd3, 32'd3);
    expect_done("t1", 32'd6);

    // Single word at index 0 (reads as 0 regardless of storage)
    regs[0] = 32'h1234;
    start_dump(5'd0, 5'd0);
    expect_beat("t2b0", 5'd0, 32'd0);
    expect_done("t2", 32'd0);

    // Wrapping range 31,0,1 with modular checksum
    regs[31] = 32'hFFFF_FFFF; regs[1] = 32'd5;
    start_dump(5'd31, 5'd1);
    expect_beat("t3b31", 5'd31, 32'hFFFF_FFFF);
    expect_beat("t3b0", 5'd0, 32'd0);
    expect_beat("t3b1", 5'd1, 32'd5);
    expect_done("t3", 32'd4);

    // Backpressure on the first beat of 1..2, with a stray Start
    Ready = 1'b0;
    start_dump(5'd1, 5'd2);
    chk("t4_fetch_ra", {27'd0, Ra}, 32'd1);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("t4_hold_valid", {31'd0, Valid}, 32'd1);
      chk("t4_hold_dout", Dout, 32'd5);
      chk("t4_hold_idx", {27'd0, Idx}, 32'd1);
      chk("t4_hold_sum", Sum, 32'd0);
      Start = (c == 2);
      First = 5'd9;
      Last  = 5'd9;
      tick();
    end
    Start = 1'b0;
    chk("t4_still_valid", {31'd0, Valid}, 32'd1);
    Ready = 1'b1;
    tick();
    chk("t4_sum_after", Sum, 32'd5);
    expect_beat("t4b2", 5'd2, 32'd2);
    expect_done("t4", 32'd7);

    // Abort coinciding with the second handshake of 1..3
    regs[1] = 32'd1;
    start_dump(5'd1, 5'd3);
    expect_beat("t5b1", 5'd1, 32'd1);
    chk("t5_fetch_ra", {27'd0, Ra}, 32'd2);
    tick();
    chk("t5_send_valid", {31'd0, Valid}, 32'd1);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("t5_abort_valid", {31'd0, Valid}, 32'd0);
    chk("t5_abort_busy", {31'd0, Busy}, 32'd0);
    chk("t5_abort_done", {31'd0, Done}, 32'd0);
    chk("t5_abort_sum", Sum, 32'd1);
    tick();
    chk("t5_no_done_late", {31'd0, Done}, 32'd0);
    start_dump(5'd3, 5'd3);
    expect_beat("t5r3", 5'd3, 32'd3);
    expect_done("t5r", 32'd3);

    // Clr during SEND
    start_dump(5'd1, 5'd3);
    tick();
    chk("t6_send_valid", {31'd0, Valid}, 32'd1);
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    chk("t6_clr_valid", {31'd0, Valid}, 32'd0);
    chk("t6_clr_busy", {31'd0, Busy}, 32'd0);
    chk("t6_clr_done", {31'd0, Done}, 32'd0);
    chk("t6_clr_ra", {27'd0, Ra}, 32'd0);
    chk("t6_clr_dout", Dout, 32'd0);
    chk("t6_clr_idx", {27'd0, Idx}, 32'd0);
    chk("t6_clr_sum", Sum, 32'd0);
    tick();
    chk("t6_idle_busy", {31'd0, Busy}, 32'd0);

    // Snapshot: write R2 while its word waits; Start+Abort in IDLE accepted
    Ready = 1'b0;
    Abort = 1'b1;
    start_dump(5'd2, 5'd2);
    Abort = 1'b0;
    chk("t7_start_abort_busy", {31'd0, Busy}, 32'd1);
    tick();
    chk("t7_send_dout", Dout, 32'd2);
    regs[2] = 32'hAA;
    tick();
    chk("t7_snap_dout", Dout, 32'd2);
    chk("t7_snap_valid", {31'd0, Valid}, 32'd1);
    Ready = 1'b1;
    tick();
    expect_done("t7", 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
